// File: rtl/arm_mem_responder_if.sv
// Request/response bus between the core's address/fetch path and the memory responder.
interface arm_mem_responder_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic        byte_en;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        abort;
  logic        busy;

  modport master (output req, addr, we, byte_en, wdata,
                  input  rdata, ready, abort, busy);

  modport slave  (input  req, addr, we, byte_en, wdata,
                  output rdata, ready, abort, busy);
endinterface

// File: rtl/arm_mem_responder.sv
// Memory-side responder: latches one request, waits WAIT_STATES cycles, then commits a write or
// returns little-endian read data with ARM-style byte replication and word rotation.
module arm_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  arm_mem_responder_if.slave   bus
);

  localparam int         IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT    = 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic        byte_q, byte_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [4:0]       lane_sh;
  logic [31:0]      word;
  logic [31:0]      word_rot;
  logic [7:0]       sel_byte;
  logic [31:0]      rd_fmt;
  logic             resp;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      byte_q  <= byte_d;
    end
  end

  // Requests are only sampled in IDLE; anything arriving while busy is dropped, not queued.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    byte_d  = byte_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          we_d    = bus.we;
          byte_d  = bus.byte_en;
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Word reads rotate right by the byte offset; byte reads replicate the lane on all four lanes.
  always_comb begin
    in_range = ({1'b0, addr_q} < LIMIT);
    idx      = addr_q[IDX_W+1:2];
    lane_sh  = {addr_q[1:0], 3'b000};
    word     = mem[idx];
    word_rot = (word >> lane_sh) | (word << (6'd32 - {1'b0, lane_sh}));
    sel_byte = word[lane_sh +: 8];
    rd_fmt   = byte_q ? {4{sel_byte}} : word_rot;
    resp     = (state_q == S_RESP);
  end

  assign bus.ready = resp;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.abort = resp && !in_range;
  assign bus.rdata = (resp && !we_q && in_range) ? rd_fmt : 32'h0;

  // The array has no reset; a write lands on the edge that ends the RESP cycle.
  always_ff @(posedge clk1) begin
    if (resp && we_q && in_range) begin
      if (byte_q) begin
        mem[idx][lane_sh +: 8] <= wdata_q[7:0];
      end else begin
        mem[idx] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_arm_mem_responder.sv
// Bench for arm_mem_responder: directed scenarios plus randomized accesses checked against a
// byte-array reference model of the memory.
module tb_arm_mem_responder;

  localparam int WS2 = 2;

  logic clk1  = 1'b0;
  logic rst_n = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] model_b [1024];

  arm_mem_responder_if bus2();
  arm_mem_responder_if bus0();

  arm_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(WS2)) dut (
    .clk1 (clk1),
    .rst_n(rst_n),
    .bus  (bus2.slave)
  );

  arm_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk1 (clk1),
    .rst_n(rst_n),
    .bus  (bus0.slave)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference: little-endian bytes; word read result byte k comes from byte (k + offset) mod 4.
  function automatic logic [31:0] model_read(input logic [31:0] a, input logic b);
    logic [31:0] r;
    int ai, base;
    r = 32'h0;
    if (a >= 32'd1024) return r;
    ai   = int'(a);
    base = (ai / 4) * 4;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = b ? model_b[ai] : model_b[base + ((k + (ai % 4)) % 4)];
    end
    return r;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic b, input logic [31:0] d);
    int ai, base;
    if (a >= 32'd1024) return;
    ai   = int'(a);
    base = (ai / 4) * 4;
    if (b) begin
      model_b[ai] = d[7:0];
    end else begin
      for (int k = 0; k < 4; k++) model_b[base + k] = d[8*k +: 8];
    end
  endfunction

  // lat = number of clock edges after the accepting edge before ready is seen.
  task automatic run_access(input bit on0, input logic w, input logic b, input logic [31:0] a,
                            input logic [31:0] d, output int lat, output int busy_n,
                            output logic [31:0] rd, output logic ab, output int stray);
    logic rdy, bsy, abt;
    logic [31:0] rdt;
    lat = -1; busy_n = 0; rd = 32'h0; ab = 1'b0; stray = 0;
    @(negedge clk1);
    if (on0) begin
      bus0.req = 1'b1; bus0.addr = a; bus0.we = w; bus0.byte_en = b; bus0.wdata = d;
    end else begin
      bus2.req = 1'b1; bus2.addr = a; bus2.we = w; bus2.byte_en = b; bus2.wdata = d;
    end
    @(posedge clk1); #1;
    if (on0) begin
      bus0.req = 1'b0; bus0.addr = $urandom; bus0.we = ~w; bus0.byte_en = ~b; bus0.wdata = $urandom;
    end else begin
      bus2.req = 1'b0; bus2.addr = $urandom; bus2.we = ~w; bus2.byte_en = ~b; bus2.wdata = $urandom;
    end
    for (int i = 0; i < 40; i++) begin
      rdy = on0 ? bus0.ready : bus2.ready;
      bsy = on0 ? bus0.busy  : bus2.busy;
      abt = on0 ? bus0.abort : bus2.abort;
      rdt = on0 ? bus0.rdata : bus2.rdata;
      if (bsy) busy_n++;
      if (rdy) begin
        lat = i; rd = rdt; ab = abt;
        break;
      end
      if (rdt !== 32'h0 || abt !== 1'b0) stray++;
      @(posedge clk1); #1;
    end
    if (lat >= 0) begin
      @(posedge clk1); #1;
      rdy = on0 ? bus0.ready : bus2.ready;
      bsy = on0 ? bus0.busy  : bus2.busy;
      rdt = on0 ? bus0.rdata : bus2.rdata;
      if (rdy || bsy || rdt !== 32'h0) stray++;
    end
  endtask

  task automatic test_reset;
    bus2.req = 1'b0; bus2.addr = '0; bus2.we = 1'b0; bus2.byte_en = 1'b0; bus2.wdata = '0;
    bus0.req = 1'b0; bus0.addr = '0; bus0.we = 1'b0; bus0.byte_en = 1'b0; bus0.wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk1);
    #1;
    vectors++;
    if ({bus2.ready, bus2.busy, bus2.abort, bus2.rdata} !== 35'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs_ws2: got %h required 0", {bus2.ready, bus2.busy, bus2.abort, bus2.rdata});
    end
    vectors++;
    if ({bus0.ready, bus0.busy, bus0.abort, bus0.rdata} !== 35'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs_ws0: got %h required 0", {bus0.ready, bus0.busy, bus0.abort, bus0.rdata});
    end
    @(negedge clk1);
    rst_n = 1'b1;
  endtask

  task automatic fill_memory;
    int lat, bn, st;
    logic [31:0] rd, d;
    logic ab;
    for (int w = 0; w < 256; w++) begin
      d = $urandom;
      run_access(1'b0, 1'b1, 1'b0, 32'(w * 4), d, lat, bn, rd, ab, st);
      model_write(32'(w * 4), 1'b0, d);
    end
  endtask

  task automatic test_word_rw;
    int lat, bn, st;
    logic [31:0] rd;
    logic ab;
    run_access(1'b0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, lat, bn, rd, ab, st);
    model_write(32'h10, 1'b0, 32'hDEADBEEF);
    vectors++;
    if (lat !== WS2) begin miscompares++; $display("[TB] FAIL word_write_latency: got %0d required %0d", lat, WS2); end
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("[TB] FAIL word_write_rdata: got %h required 0", rd); end
    run_access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, lat, bn, rd, ab, st);
    vectors++;
    if (lat !== WS2) begin miscompares++; $display("[TB] FAIL word_read_latency: got %0d required %0d", lat, WS2); end
    vectors++;
    if (rd !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL word_read_rdata: got %h required deadbeef", rd); end
    vectors++;
    if (ab !== 1'b0) begin miscompares++; $display("[TB] FAIL word_read_abort: got %b required 0", ab); end
    vectors++;
    if (bn !== WS2 + 1) begin miscompares++; $display("[TB] FAIL word_read_busy_cycles: got %0d required %0d", bn, WS2 + 1); end
    vectors++;
    if (st !== 0) begin miscompares++; $display("[TB] FAIL word_read_stray: got %0d required 0", st); end
  endtask

  task automatic test_byte_lanes;
    int lat, bn, st;
    logic [31:0] rd;
    logic ab;
    run_access(1'b0, 1'b1, 1'b1, 32'h11, 32'h123456AA, lat, bn, rd, ab, st);
    model_write(32'h11, 1'b1, 32'h123456AA);
    run_access(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, lat, bn, rd, ab, st);
    vectors++;
    if (rd !== 32'hDEADAAEF) begin miscompares++; $display("[TB] FAIL byte_write_lane1: got %h required deadaaef", rd); end
    run_access(1'b0, 1'b0, 1'b1, 32'h13, 32'h0, lat, bn, rd, ab, st);
    vectors++;
    if (rd !== 32'hDEDEDEDE) begin miscompares++; $display("[TB] FAIL byte_read_replicate: got %h required dededede", rd); end
  endtask

  task automatic test_misaligned;
    int lat, bn, st;
    logic [31:0] rd;
    logic ab;
    run_access(1'b0, 1'b0, 1'b0, 32'h12, 32'h0, lat, bn, rd, ab, st);
    vectors++;
    if (rd !== 32'hAAEFDEAD) begin miscompares++; $display("[TB] FAIL misaligned_read_0x12: got %h required aaefdead", rd); end
    run_access(1'b0, 1'b0, 1'b0, 32'h11, 32'h0, lat, bn, rd, ab, st);
    vectors++;
    if (rd !== 32'hEFDEADAA) begin miscompares++; $display("[TB] FAIL misaligned_read_0x11: got %h required efdeadaa", rd); end
  endtask

  task automatic test_out_of_range;
    int lat, bn, st, bad;
    logic [31:0] rd, exp;
    logic ab;
    run_access(1'b0, 1'b1, 1'b0, 32'h400, 32'h12345678, lat, bn, rd, ab, st);
    vectors++;
    if ({lat == WS2, ab, rd} !== {1'b1, 1'b1, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL oor_write: got lat=%0d abort=%b rdata=%h required lat=%0d abort=1 rdata=0", lat, ab, rd, WS2);
    end
    run_access(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, lat, bn, rd, ab, st);
    vectors++;
    if ({ab, rd} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("[TB] FAIL oor_read_top: got abort=%b rdata=%h required abort=1 rdata=0", ab, rd);
    end
    bad = 0;
    for (int w = 0; w < 256; w++) begin
      run_access(1'b0, 1'b0, 1'b0, 32'(w * 4), 32'h0, lat, bn, rd, ab, st);
      exp = model_read(32'(w * 4), 1'b0);
      vectors++;
      if (rd !== exp || ab !== 1'b0) begin
        miscompares++;
        if (bad < 5) $display("[TB] FAIL oor_sweep word %0d: got %h abort=%b required %h abort=0", w, rd, ab, exp);
        bad++;
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] addrs [8];
    int exp_edges [$];
    logic [31:0] exp_rd [$];
    int got_edges [$];
    logic [31:0] got_rd [$];
    int next_free;
    for (int i = 0; i < 8; i++) addrs[i] = 32'($urandom_range(0, 1023));
    next_free = 0;
    for (int e = 0; e < 8; e++) begin
      if (e >= next_free) begin
        exp_edges.push_back(e + WS2);
        exp_rd.push_back(model_read(addrs[e], 1'b0));
        next_free = e + WS2 + 2;
      end
    end
    for (int e = 0; e < 12; e++) begin
      @(negedge clk1);
      bus2.req = (e < 8); bus2.we = 1'b0; bus2.byte_en = 1'b0;
      bus2.addr = (e < 8) ? addrs[e] : 32'h0;
      @(posedge clk1); #1;
      if (bus2.ready) begin
        got_edges.push_back(e);
        got_rd.push_back(bus2.rdata);
      end
    end
    bus2.req = 1'b0;
    vectors++;
    if (got_edges.size() !== exp_edges.size()) begin
      miscompares++;
      $display("[TB] FAIL b2b_ready_count: got %0d required %0d", got_edges.size(), exp_edges.size());
    end else begin
      foreach (exp_edges[i]) begin
        vectors++;
        if (got_edges[i] !== exp_edges[i] || got_rd[i] !== exp_rd[i]) begin
          miscompares++;
          $display("[TB] FAIL b2b_pulse %0d: got edge %0d rdata %h required edge %0d rdata %h", i, got_edges[i], got_rd[i], exp_edges[i], exp_rd[i]);
        end
      end
    end
    @(posedge clk1); #1;
  endtask

  task automatic test_zero_wait;
    int lat, bn, st;
    logic [31:0] rd, d;
    logic ab;
    d = $urandom;
    run_access(1'b1, 1'b1, 1'b0, 32'h44, d, lat, bn, rd, ab, st);
    vectors++;
    if ({lat == 0, bn == 1, ab} !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL ws0_write: got lat=%0d busy=%0d abort=%b required lat=0 busy=1 abort=0", lat, bn, ab);
    end
    run_access(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, lat, bn, rd, ab, st);
    vectors++;
    if (lat !== 0 || rd !== d || st !== 0) begin
      miscompares++;
      $display("[TB] FAIL ws0_read: got lat=%0d rdata=%h stray=%0d required lat=0 rdata=%h stray=0", lat, rd, st, d);
    end
  endtask

  task automatic test_reset_mid_access;
    int lat, bn, st, pulses;
    logic [31:0] rd, exp;
    logic ab;
    exp = model_read(32'h20, 1'b0);
    @(negedge clk1);
    bus2.req = 1'b1; bus2.addr = 32'h20; bus2.we = 1'b1; bus2.byte_en = 1'b0; bus2.wdata = 32'h55AA55AA;
    @(posedge clk1); #1;
    bus2.req = 1'b0;
    vectors++;
    if (bus2.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL midreset_busy_before: got %b required 1", bus2.busy); end
    @(negedge clk1);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus2.ready, bus2.busy, bus2.abort, bus2.rdata} !== 35'h0) begin
      miscompares++;
      $display("[TB] FAIL midreset_outputs: got %h required 0", {bus2.ready, bus2.busy, bus2.abort, bus2.rdata});
    end
    @(posedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk1); #1;
      if (bus2.ready) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin miscompares++; $display("[TB] FAIL midreset_ready: got %0d pulses required 0", pulses); end
    run_access(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, lat, bn, rd, ab, st);
    vectors++;
    if (rd !== exp) begin miscompares++; $display("[TB] FAIL midreset_contents: got %h required %h", rd, exp); end
  endtask

  task automatic test_random;
    int lat, bn, st;
    logic [31:0] rd, a, d, exp_rd;
    logic ab, w, b, oor;
    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      d = $urandom;
      if ($urandom_range(0, 7) == 0) a = $urandom | 32'h400;
      else a = 32'($urandom_range(0, 1023));
      oor    = (a >= 32'd1024);
      exp_rd = (w || oor) ? 32'h0 : model_read(a, b);
      run_access(1'b0, w, b, a, d, lat, bn, rd, ab, st);
      if (w) model_write(a, b, d);
      vectors++;
      if (rd !== exp_rd || ab !== oor || lat !== WS2 || st !== 0) begin
        miscompares++;
        $display("[TB] FAIL random %0d (we=%b byte=%b addr=%h): got rdata=%h abort=%b lat=%0d stray=%0d required rdata=%h abort=%b lat=%0d stray=0",
                 n, w, b, a, rd, ab, lat, st, exp_rd, oor, WS2);
      end
    end
  endtask

  initial begin
    test_reset();
    fill_memory();
    test_word_rw();
    test_byte_lanes();
    test_misaligned();
    test_out_of_range();
    test_back_to_back();
    test_zero_wait();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
